reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-write scoreboard for the integer pipeline. It counts in-flight writes to each architectural register, from issue (ID→EX) through writeback or squash. It drives the hazard unit's `reg_write_bitmap` and `scoreboard_enable` inputs, and it gates issue on counter overflow and on drain requests (e.g. before CSR/fence). It sits between the decode/issue logic and the hazard unit.

## Interface
- NUM_REGS, 32, architectural registers; x0 never tracked
- CNT_W, 2, per-register in-flight counter width; max = 2^CNT_W−1
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  instruction leaving ID this cycle
- issue_reg_write  in  1  issuing instruction writes rd
- issue_rd  in  5  destination of issuing instruction
- issue_ready  out  1  scoreboard accepts an issue this cycle (combinational)
- wb_valid  in  1  instruction retiring in WB
- wb_reg_write  in  1  retiring instruction writes rd
- wb_rd  in  5  destination of retiring instruction
- kill_valid  in  1  instruction squashed by mispredict flush
- kill_reg_write  in  1  squashed instruction had reg_write
- kill_rd  in  5  destination of squashed instruction
- drain_req  in  1  one-cycle request: block issue until no writes in flight
- drain_done  out  1  one-cycle pulse when drain completes
- query_rs1, query_rs2  in  5  ID-stage source operands
- busy_rs1, busy_rs2  out  1  source has write in flight (combinational from registered state)
- reg_write_bitmap  out  32  bit r = counter[r] ≠ 0; bit 0 always 0
- scoreboard_enable  out  1  scoreboard state valid; hazard unit may trust the bitmap
- outstanding  out  8  total in-flight writes, sum of all counters
- sb_error  out  1  sticky: decrement of a zero counter was attempted

## Operation
- FSM states: INIT, RUN, DRAIN.
  - INIT: entered on reset; lasts exactly one cycle after rst_n goes high, then RUN.
  - RUN → DRAIN on drain_req.
  - DRAIN → RUN when outstanding == 0 (evaluated on registered state); drain_done pulses on that transition.
  - drain_req in DRAIN or INIT is ignored.
- Accepted issue: issue_valid && issue_ready && issue_reg_write && issue_rd ≠ 0. Increments counter[issue_rd].
- issue_ready = (state == RUN) && !(issue_reg_write && issue_rd ≠ 0 && counter[issue_rd] == max && no same-rd decrement this cycle).
  - Issue with issue_reg_write = 0 or rd = 0 is ready whenever state == RUN.
- Retire: wb_valid && wb_reg_write && wb_rd ≠ 0 decrements counter[wb_rd].
- Squash: kill_valid && kill_reg_write && kill_rd ≠ 0 decrements counter[kill_rd].
- Per-register next value = counter + inc − dec_wb − dec_kill, all applied in the same cycle:
  - issue + wb to same rd → unchanged
  - wb + kill to same rd → −2
  - all three to same rd → −1
- Underflow: if the decrements exceed counter + inc, the counter saturates at 0 and sb_error sets. sb_error clears only on reset.
- busy_rsN = reg_write_bitmap[query_rsN]; always 0 for x0.
- outstanding is registered and updated with the same net delta as the counters, clamped at 0.
- scoreboard_enable = (state ≠ INIT).

## Timing
- Reset values: all counters 0, reg_write_bitmap 0, outstanding 0, sb_error 0, drain_done 0, scoreboard_enable 0, issue_ready 0, state INIT.
- Reset asserted mid-operation discards all counters on the next edge.
- Counter and bitmap updates become visible the cycle after the event edge (1-cycle latency). The same-cycle issue/wb/kill net is applied at one edge.
- Issue handshake is sampled at the rising edge. issue_ready may depend combinationally on the issue_* and wb_*/kill_* inputs; no dependency on issue_valid.
- DRAIN:
  - issue_ready = 0 from the cycle after drain_req.
  - wb and kill continue to decrement.
  - If outstanding is already 0 when drain_req is sampled: DRAIN for exactly one cycle, drain_done in the following cycle together with the return to RUN.

## Test plan
- Reset then release → cycle 1: scoreboard_enable = 0, issue_ready = 0. Cycle 2: scoreboard_enable = 1, bitmap = 0, outstanding = 0.
- Issue rd = 5 → next cycle bitmap[5] = 1, busy_rs1 = 1 for query_rs1 = 5, outstanding = 1. wb rd = 5 → bitmap = 0.
- Issue rd = 3 three times (CNT_W = 2) → issue_ready = 0 for rd = 3 and bitmap[3] = 1. Same cycle wb rd = 3 → issue_ready = 1, counter stays 3.
- Issue rd = 7 with simultaneous wb rd = 7 and kill rd = 7, counter[7] = 2 beforehand → counter[7] = 1, outstanding decreases by 1. Issue rd = 0 → bitmap unchanged.
- wb rd = 9 with counter[9] = 0 → sb_error = 1 and remains 1. Counter[9] stays 0.
- Two writes in flight, then drain_req → issue_ready = 0 next cycle. After both retire, drain_done pulses once, state returns to RUN, issue_ready = 1.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register in-flight write counters feeding the
// hazard unit, with issue gating on counter saturation and drain requests.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_reg_write,
  input  logic [4:0]          issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_rd,
  input  logic                kill_valid,
  input  logic                kill_reg_write,
  input  logic [4:0]          kill_rd,
  input  logic                drain_req,
  output logic                drain_done,
  input  logic [4:0]          query_rs1,
  input  logic [4:0]          query_rs2,
  output logic                busy_rs1,
  output logic                busy_rs2,
  output logic [NUM_REGS-1:0] reg_write_bitmap,
  output logic                scoreboard_enable,
  output logic [7:0]          outstanding,
  output logic                sb_error
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W+1:0] ONE     = 1;

  state_t           state;
  state_t           state_next;
  logic             drain_done_next;

  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic [CNT_W+1:0] cnt_tmp;
  logic [7:0]       outstanding_next;
  logic             underflow;

  logic             issue_wr;
  logic             issue_acc;
  logic             wb_dec;
  logic             kill_dec;
  logic             same_rd_dec;

  assign issue_wr    = issue_reg_write && (issue_rd != 5'd0);
  assign wb_dec      = wb_valid && wb_reg_write && (wb_rd != 5'd0);
  assign kill_dec    = kill_valid && kill_reg_write && (kill_rd != 5'd0);
  assign same_rd_dec = (wb_dec && (wb_rd == issue_rd)) ||
                       (kill_dec && (kill_rd == issue_rd));

  // A saturated counter may still accept an issue if the same register retires
  // or is squashed in this cycle, since the net change then cannot overflow.
  assign issue_ready = (state == RUN) &&
                       !(issue_wr && (cnt[issue_rd] == CNT_MAX) && !same_rd_dec);
  assign issue_acc   = issue_valid && issue_ready && issue_wr;

  assign scoreboard_enable = (state != INIT);
  assign busy_rs1          = reg_write_bitmap[query_rs1];
  assign busy_rs2          = reg_write_bitmap[query_rs2];

  always_comb begin
    reg_write_bitmap = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      reg_write_bitmap[r] = |cnt[r];
    end
  end

  // Net issue/wb/kill delta per register, saturating at zero on underflow.
  // outstanding tracks the sum of the updated counters, so it can never go
  // below zero nor drift from the per-register state after an underflow.
  always_comb begin
    underflow        = 1'b0;
    outstanding_next = '0;
    cnt_tmp          = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = '0;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_tmp = {2'b00, cnt[r]};
      if (issue_acc && (issue_rd == 5'(r))) cnt_tmp = cnt_tmp + ONE;
      if (wb_dec && (wb_rd == 5'(r)))       cnt_tmp = cnt_tmp - ONE;
      if (kill_dec && (kill_rd == 5'(r)))   cnt_tmp = cnt_tmp - ONE;
      if (cnt_tmp[CNT_W+1]) begin
        cnt_next[r] = '0;
        underflow   = 1'b1;
      end else if (cnt_tmp[CNT_W]) begin
        cnt_next[r] = CNT_MAX;
      end else begin
        cnt_next[r] = cnt_tmp[CNT_W-1:0];
      end
      outstanding_next = outstanding_next + 8'(cnt_next[r]);
    end
  end

  always_comb begin
    state_next      = state;
    drain_done_next = 1'b0;
    case (state)
      INIT:  state_next = RUN;
      RUN:   if (drain_req) state_next = DRAIN;
      DRAIN: begin
        if (outstanding == 8'd0) begin
          state_next      = RUN;
          drain_done_next = 1'b1;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      drain_done <= 1'b0;
    end else begin
      state      <= state_next;
      drain_done <= drain_done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      outstanding <= '0;
      sb_error    <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_next[r];
      end
      outstanding <= outstanding_next;
      if (underflow) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: reset, issue/retire/kill
// arithmetic, saturation gating, underflow, drain handshake and mid-run reset.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_reg_write;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic        kill_valid;
  logic        kill_reg_write;
  logic [4:0]  kill_rd;
  logic        drain_req;
  logic        drain_done;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic [31:0] reg_write_bitmap;
  logic        scoreboard_enable;
  logic [7:0]  outstanding;
  logic        sb_error;

  int checks;
  int errors;

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .issue_valid       (issue_valid),
    .issue_reg_write   (issue_reg_write),
    .issue_rd          (issue_rd),
    .issue_ready       (issue_ready),
    .wb_valid          (wb_valid),
    .wb_reg_write      (wb_reg_write),
    .wb_rd             (wb_rd),
    .kill_valid        (kill_valid),
    .kill_reg_write    (kill_reg_write),
    .kill_rd           (kill_rd),
    .drain_req         (drain_req),
    .drain_done        (drain_done),
    .query_rs1         (query_rs1),
    .query_rs2         (query_rs2),
    .busy_rs1          (busy_rs1),
    .busy_rs2          (busy_rs2),
    .reg_write_bitmap  (reg_write_bitmap),
    .scoreboard_enable (scoreboard_enable),
    .outstanding       (outstanding),
    .sb_error          (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's worth of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic iv, input logic iw, input logic [4:0] ird,
                               input logic wv, input logic [4:0] wrd,
                               input logic kv, input logic [4:0] krd,
                               input logic dr);
    issue_valid     = iv;
    issue_reg_write = iw;
    issue_rd        = ird;
    wb_valid        = wv;
    wb_reg_write    = wv;
    wb_rd           = wrd;
    kill_valid      = kv;
    kill_reg_write  = kv;
    kill_rd         = krd;
    drain_req       = dr;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    query_rs1 = 5'd0;
    query_rs2 = 5'd0;
    idle();
    step();
    step();
    checkOutput("rst_enable", scoreboard_enable, 0);
    checkOutput("rst_bitmap", reg_write_bitmap, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_sb_error", sb_error, 0);
    checkOutput("rst_drain_done", drain_done, 0);
    checkOutput("rst_ready", issue_ready, 0);

    rst_n = 1'b1;
    #1;
    checkOutput("init_enable", scoreboard_enable, 0);
    checkOutput("init_ready", issue_ready, 0);
    step();
    checkOutput("run_enable", scoreboard_enable, 1);
    checkOutput("run_bitmap", reg_write_bitmap, 0);
    checkOutput("run_outstanding", outstanding, 0);

    applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("issue5_ready", issue_ready, 1);
    step();
    idle();
    query_rs1 = 5'd5;
    query_rs2 = 5'd6;
    #1;
    checkOutput("issue5_bitmap", reg_write_bitmap, 32'h0000_0020);
    checkOutput("issue5_busy_rs1", busy_rs1, 1);
    checkOutput("issue5_busy_rs2", busy_rs2, 0);
    checkOutput("issue5_outstanding", outstanding, 1);

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    step();
    idle();
    checkOutput("wb5_bitmap", reg_write_bitmap, 0);
    checkOutput("wb5_busy_rs1", busy_rs1, 0);
    checkOutput("wb5_outstanding", outstanding, 0);

    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    step();
    #1;
    checkOutput("sat3_ready", issue_ready, 0);
    checkOutput("sat3_bitmap", reg_write_bitmap, 32'h0000_0008);
    checkOutput("sat3_outstanding", outstanding, 3);
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    checkOutput("sat3_wb_ready", issue_ready, 1);
    step();
    idle();
    checkOutput("sat3_wb_outstanding", outstanding, 3);
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("sat3_still_full", issue_ready, 0);
    applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("rd0_ready", issue_ready, 1);
    applyStimulus(1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("nowrite_ready", issue_ready, 1);

    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    idle();
    checkOutput("issue7x2_outstanding", outstanding, 5);
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    checkOutput("triple7_ready", issue_ready, 1);
    step();
    idle();
    checkOutput("triple7_outstanding", outstanding, 4);
    checkOutput("triple7_bitmap", reg_write_bitmap, 32'h0000_0088);

    applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    idle();
    checkOutput("rd0_bitmap", reg_write_bitmap, 32'h0000_0088);
    checkOutput("rd0_outstanding", outstanding, 4);

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    step();
    idle();
    checkOutput("uflow_sb_error", sb_error, 1);
    checkOutput("uflow_bitmap", reg_write_bitmap, 32'h0000_0088);
    checkOutput("uflow_outstanding", outstanding, 4);
    step();
    checkOutput("uflow_sticky", sb_error, 1);

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0);
    step();
    idle();
    checkOutput("wbkill3_outstanding", outstanding, 2);
    checkOutput("wbkill3_bitmap", reg_write_bitmap, 32'h0000_0088);

    applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    checkOutput("drain_req_ready", issue_ready, 1);
    step();
    applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_ready", issue_ready, 0);
    checkOutput("drain_enable", scoreboard_enable, 1);
    checkOutput("drain_done_early", drain_done, 0);
    applyStimulus(1'b0, 1'b1, 5'd10, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_wb3_outstanding", outstanding, 1);
    checkOutput("drain_wb3_ready", issue_ready, 0);
    applyStimulus(1'b0, 1'b1, 5'd10, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_empty_outstanding", outstanding, 0);
    checkOutput("drain_empty_ready", issue_ready, 0);
    checkOutput("drain_empty_done", drain_done, 0);
    step();
    checkOutput("drain_done_pulse", drain_done, 1);
    checkOutput("drain_back_ready", issue_ready, 1);
    step();
    checkOutput("drain_done_once", drain_done, 0);

    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    step();
    idle();
    checkOutput("zdrain_ready", issue_ready, 0);
    checkOutput("zdrain_done_early", drain_done, 0);
    step();
    checkOutput("zdrain_done", drain_done, 1);
    checkOutput("zdrain_ready_back", issue_ready, 1);
    step();
    checkOutput("zdrain_done_once", drain_done, 0);

    applyStimulus(1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    idle();
    checkOutput("pre_rst_bitmap", reg_write_bitmap, 32'h0000_1000);
    rst_n = 1'b0;
    step();
    checkOutput("midrst_bitmap", reg_write_bitmap, 0);
    checkOutput("midrst_outstanding", outstanding, 0);
    checkOutput("midrst_sb_error", sb_error, 0);
    checkOutput("midrst_enable", scoreboard_enable, 0);
    rst_n = 1'b1;
    step();
    checkOutput("postrst_enable", scoreboard_enable, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
